playlist_sequencer: RTL and testbench
=====================================

// Module: playlist_sequencer
// PURPOSE
// Sequences the song reader across a playlist: picks the song index, drives play, and pulses
// a reader restart on every song change. Handles user play/pause/next/prev, emotion-driven
// song requests and end-of-song auto-advance with a beat-counted inter-song gap.
// Sits between UI/emotion classifier and the song reader, whose song_done is sticky until restart.
// PARAMETERS
// NUM_SONGS  4  number of playlist entries, 1..4; index width fixed at 2 bits
// GAP_BEATS  8  beats of silence between songs on auto-advance; 0 = no gap
// PORTS
// clk          in   1  system clock
// reset        in   1  asynchronous, active-high reset
// beat         in   1  one-cycle beat strobe (same as reader beat)
// play_pause   in   1  one-cycle pulse: toggle play/pause, or start from idle
// next_btn     in   1  one-cycle pulse: skip to next song
// prev_btn     in   1  one-cycle pulse: go to previous song
// emo_valid    in   1  one-cycle pulse: emotion classifier requests a song
// emo_song     in   2  requested song index, valid with emo_valid
// loop_all     in   1  level: wrap to song 0 after last song instead of stopping
// loop_one     in   1  level: auto-advance repeats the current song
// song_done    in   1  reader end-of-song flag (sticky until reader_rst)
// play         out  1  reader play enable
// song         out  2  reader song select
// reader_rst   out  1  one-cycle restart pulse to reader (ORed into its reset)
// gap_active   out  1  high while in inter-song gap
// state_o      out  3  current FSM state encoding (debug)
// BEHAVIOUR
// - States: IDLE=0, LOAD=1, PLAYING=2, PAUSED=3, GAP=4; others -> IDLE next cycle.
// - Reset: state IDLE, song=0, play=0, reader_rst=0, gap_active=0, gap counter=0. Reset mid-song
//   aborts immediately; no reader_rst issued.
// - All outputs registered; a decision on cycle N is visible on cycle N+1.
// - Same-cycle input priority: emo_valid > next_btn > prev_btn > play_pause > song_done.
// - Index math mod NUM_SONGS: next = song+1, NUM_SONGS-1 wraps to 0; prev = song-1, 0 wraps
//   to NUM_SONGS-1. emo_song >= NUM_SONGS -> emo_song mod NUM_SONGS.
// - IDLE: play=0. emo_valid -> load emo_song, LOAD. play_pause -> LOAD with current song.
//   next/prev/song_done ignored.
// - LOAD: exactly one cycle; reader_rst=1, play=0; -> PLAYING. Requests during LOAD are dropped.
// - PLAYING: play=1. emo_valid/next/prev -> new song, LOAD. play_pause -> PAUSED.
//   song_done ignored on first PLAYING cycle (reader flag clearing); afterwards song_done ->
//   GAP with counter=GAP_BEATS (GAP_BEATS=0: treat as immediate gap expiry, same cycle).
// - PAUSED: play=0, song held, reader not restarted. play_pause -> PLAYING (resume in place).
//   emo_valid/next/prev -> new song, LOAD.
// - GAP: play=0, gap_active=1. Counter decrements on beat; beat with counter==1 -> expiry.
//   Expiry: loop_one -> same song, LOAD; else if song==NUM_SONGS-1 and !loop_all -> song=0, IDLE;
//   else advance song, LOAD. play_pause -> IDLE (song held). emo_valid/next/prev -> LOAD.
// - loop_one and loop_all both high: loop_one wins.
// - NUM_SONGS=1: next/prev/advance all select song 0.
// CONFIGURATION
// - SHUFFLE_EN defined: 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset, steps every
//   clk. Auto-advance and next_btn choose lfsr[1:0] mod NUM_SONGS; if equal to current song,
//   use current+1 (wrapped). loop_all ignored in shuffle (never stops at end). prev_btn stays
//   sequential.
// - SHUFFLE_EN undefined: strictly sequential indexing as above; no LFSR logic present.
// TESTING
// - reset, play_pause@song0 -> reader_rst 1 cycle, then play=1, song=0, state_o=2.
// - PLAYING song=3, next_btn -> song=0, reader_rst pulse, back to PLAYING; prev_btn -> song=3.
// - song_done, GAP_BEATS=8, loop_all=0, song=1 -> play=0, 8 beats, then song=2, reader_rst, play=1.
// - song_done on song=3, loop_all=0 -> after gap: IDLE, song=0, play=0; loop_all=1 -> song=0, LOAD.
// - PLAYING, play_pause -> PAUSED, play=0, no reader_rst; play_pause again -> play=1, same song.
// - same cycle emo_valid(emo_song=2)+next_btn on song 0 -> song=2; SHUFFLE_EN: next never repeats song.

Source files
------------

// File: rtl/playlist_sequencer.sv
// Playlist sequencer: selects the song, drives reader play and restart, handles UI, emotion
// requests and beat-timed auto-advance. Optional SHUFFLE_EN macro enables LFSR song picks.
module playlist_sequencer #(
  parameter int NUM_SONGS = 4,
  parameter int GAP_BEATS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beat,
  input  logic       play_pause,
  input  logic       next_btn,
  input  logic       prev_btn,
  input  logic       emo_valid,
  input  logic [1:0] emo_song,
  input  logic       loop_all,
  input  logic       loop_one,
  input  logic       song_done,
  output logic       play,
  output logic [1:0] song,
  output logic       reader_rst,
  output logic       gap_active,
  output logic [2:0] state_o
);

  localparam int CW = (GAP_BEATS < 2) ? 1 : $clog2(GAP_BEATS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PLAYING = 3'd2,
    PAUSED  = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    song_q, song_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  logic          play_q, reader_rst_q, gap_active_q;

  logic [1:0]    next_idx_s;
  logic          stop_at_end_s;
  logic          req_s;
  logic [1:0]    req_song_s;
  state_t        exp_state_s;
  logic [1:0]    exp_song_s;

  function automatic logic [1:0] wrap_idx(input logic [1:0] v);
    wrap_idx = 2'(int'(v) % NUM_SONGS);
  endfunction

  function automatic logic [1:0] inc_idx(input logic [1:0] v);
    if (int'(v) >= NUM_SONGS - 1) begin
      inc_idx = 2'd0;
    end else begin
      inc_idx = v + 2'd1;
    end
  endfunction

  function automatic logic [1:0] dec_idx(input logic [1:0] v);
    if (v == 2'd0) begin
      dec_idx = 2'(NUM_SONGS - 1);
    end else begin
      dec_idx = v - 2'd1;
    end
  endfunction

`ifdef SHUFFLE_EN
  logic [7:0] lfsr_q;
  logic [1:0] shuf_pick_s;

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Random pick that never repeats the current song
  always_comb begin
    shuf_pick_s = wrap_idx(lfsr_q[1:0]);
    if (shuf_pick_s == song_q) begin
      shuf_pick_s = inc_idx(song_q);
    end else begin
      shuf_pick_s = shuf_pick_s;
    end
  end

  assign next_idx_s    = shuf_pick_s;
  assign stop_at_end_s = 1'b0;
`else
  assign next_idx_s    = inc_idx(song_q);
  assign stop_at_end_s = (int'(song_q) == NUM_SONGS - 1) && !loop_all;
`endif

  // Song-change requests: emotion beats next beats prev
  always_comb begin
    req_s = emo_valid | next_btn | prev_btn;
    if (emo_valid) begin
      req_song_s = wrap_idx(emo_song);
    end else if (next_btn) begin
      req_song_s = next_idx_s;
    end else begin
      req_song_s = dec_idx(song_q);
    end
  end

  // Outcome of an expired inter-song gap
  always_comb begin
    if (loop_one) begin
      exp_state_s = LOAD;
      exp_song_s  = song_q;
    end else if (stop_at_end_s) begin
      exp_state_s = IDLE;
      exp_song_s  = 2'd0;
    end else begin
      exp_state_s = LOAD;
      exp_song_s  = next_idx_s;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (emo_valid) begin
          state_d = LOAD;
          song_d  = wrap_idx(emo_song);
        end else if (play_pause) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = PLAYING;
      end
      PLAYING: begin
        if (req_s) begin
          state_d = LOAD;
          song_d  = req_song_s;
        end else if (play_pause) begin
          state_d = PAUSED;
        end else if (song_done && !first_q) begin
          if (GAP_BEATS == 0) begin
            state_d = exp_state_s;
            song_d  = exp_song_s;
          end else begin
            state_d = GAP;
            cnt_d   = CW'(GAP_BEATS);
          end
        end else begin
          state_d = PLAYING;
        end
      end
      PAUSED: begin
        if (req_s) begin
          state_d = LOAD;
          song_d  = req_song_s;
        end else if (play_pause) begin
          state_d = PLAYING;
        end else begin
          state_d = PAUSED;
        end
      end
      GAP: begin
        if (req_s) begin
          state_d = LOAD;
          song_d  = req_song_s;
        end else if (play_pause) begin
          state_d = IDLE;
        end else if (beat) begin
          if (cnt_q <= CW'(1)) begin
            state_d = exp_state_s;
            song_d  = exp_song_s;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != GAP) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_d;
    end
    // Reader's sticky done flag is still set on the first PLAYING cycle
    first_d = (state_d == PLAYING) && (state_q != PLAYING);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      song_q       <= 2'd0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      play_q       <= 1'b0;
      reader_rst_q <= 1'b0;
      gap_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      song_q       <= song_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      play_q       <= (state_d == PLAYING);
      reader_rst_q <= (state_d == LOAD);
      gap_active_q <= (state_d == GAP);
    end
  end

  assign play       = play_q;
  assign song       = song_q;
  assign reader_rst = reader_rst_q;
  assign gap_active = gap_active_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_playlist_sequencer.sv
// Table-driven bench for playlist_sequencer (NUM_SONGS=4, GAP_BEATS=8, sequential build).
module tb_playlist_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       beat, play_pause, next_btn, prev_btn, emo_valid;
  logic [1:0] emo_song;
  logic       loop_all, loop_one, song_done;
  logic       play;
  logic [1:0] song;
  logic       reader_rst, gap_active;
  logic [2:0] state_o;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic       beat, pp, nx, pv, ev;
    logic [1:0] es;
    logic       la, lo, sd;
    logic       e_play;
    logic [1:0] e_song;
    logic       e_rst, e_gap;
    logic [2:0] e_st;
  } vec_t;

  vec_t vecs[$];

  playlist_sequencer #(.NUM_SONGS(4), .GAP_BEATS(8)) dut (
    .clk(clk), .reset(reset), .beat(beat), .play_pause(play_pause),
    .next_btn(next_btn), .prev_btn(prev_btn), .emo_valid(emo_valid),
    .emo_song(emo_song), .loop_all(loop_all), .loop_one(loop_one),
    .song_done(song_done), .play(play), .song(song), .reader_rst(reader_rst),
    .gap_active(gap_active), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic add(input logic b, pp, nx, pv, ev, input logic [1:0] es,
                     input logic la, lo, sd,
                     input logic ep, input logic [1:0] esg, input logic er, eg,
                     input logic [2:0] est);
    vec_t v;
    v.beat = b; v.pp = pp; v.nx = nx; v.pv = pv; v.ev = ev; v.es = es;
    v.la = la; v.lo = lo; v.sd = sd;
    v.e_play = ep; v.e_song = esg; v.e_rst = er; v.e_gap = eg; v.e_st = est;
    vecs.push_back(v);
  endtask

  task automatic step(input logic b, pp, nx, pv, ev, input logic [1:0] es,
                      input logic la, lo, sd);
    @(negedge clk);
    beat = b; play_pause = pp; next_btn = nx; prev_btn = pv;
    emo_valid = ev; emo_song = es; loop_all = la; loop_one = lo; song_done = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic ep, input logic [1:0] esg,
                     input logic er, eg, input logic [2:0] est);
    n_vec++;
    if ({play, song, reader_rst, gap_active, state_o} !== {ep, esg, er, eg, est}) begin
      n_fail++;
      $display("FAIL %s: got play=%b song=%0d rst=%b gap=%b st=%0d, expected play=%b song=%0d rst=%b gap=%b st=%0d",
               nm, play, song, reader_rst, gap_active, state_o, ep, esg, er, eg, est);
    end
  endtask

  initial begin
    reset = 1'b1;
    beat = 1'b0; play_pause = 1'b0; next_btn = 1'b0; prev_btn = 1'b0;
    emo_valid = 1'b0; emo_song = 2'd0; loop_all = 1'b0; loop_one = 1'b0; song_done = 1'b0;

    // Inputs: beat pp nx pv ev es la lo sd | expected: play song rst gap state
    add(0,0,0,0,0,2'd0,0,0,0, 0,2'd0,0,0,3'd0);  // idle quiet
    add(0,0,1,0,0,2'd0,0,0,0, 0,2'd0,0,0,3'd0);  // idle ignores next
    add(0,0,0,1,0,2'd0,0,0,0, 0,2'd0,0,0,3'd0);  // idle ignores prev
    add(0,0,0,0,0,2'd0,0,0,1, 0,2'd0,0,0,3'd0);  // idle ignores done
    add(0,1,0,0,0,2'd0,0,0,0, 0,2'd0,1,0,3'd1);  // start -> LOAD
    add(0,0,0,0,0,2'd0,0,0,0, 1,2'd0,0,0,3'd2);  // PLAYING song 0
    add(0,0,0,0,0,2'd0,0,0,1, 1,2'd0,0,0,3'd2);  // done ignored first cycle
    add(0,0,1,0,0,2'd0,0,0,0, 0,2'd1,1,0,3'd1);  // next 0->1
    add(0,0,1,0,0,2'd0,0,0,0, 1,2'd1,0,0,3'd2);  // next during LOAD dropped
    add(0,0,0,1,0,2'd0,0,0,0, 0,2'd0,1,0,3'd1);  // prev 1->0
    add(0,0,0,0,0,2'd0,0,0,0, 1,2'd0,0,0,3'd2);
    add(0,0,0,1,0,2'd0,0,0,0, 0,2'd3,1,0,3'd1);  // prev wraps 0->3
    add(0,0,0,0,0,2'd0,0,0,0, 1,2'd3,0,0,3'd2);
    add(0,0,1,0,0,2'd0,0,0,0, 0,2'd0,1,0,3'd1);  // next wraps 3->0
    add(0,0,0,0,0,2'd0,0,0,0, 1,2'd0,0,0,3'd2);
    add(0,0,1,0,1,2'd2,0,0,0, 0,2'd2,1,0,3'd1);  // emo beats next
    add(0,0,0,0,0,2'd0,0,0,0, 1,2'd2,0,0,3'd2);
    add(0,1,0,0,0,2'd0,0,0,0, 0,2'd2,0,0,3'd3);  // pause, no restart
    add(0,0,0,0,0,2'd0,0,0,1, 0,2'd2,0,0,3'd3);  // done ignored while paused
    add(0,1,0,0,0,2'd0,0,0,0, 1,2'd2,0,0,3'd2);  // resume in place
    add(0,1,1,0,0,2'd0,0,0,0, 0,2'd3,1,0,3'd1);  // next beats play_pause
    add(0,0,0,0,0,2'd0,0,0,0, 1,2'd3,0,0,3'd2);
    add(1,0,0,0,0,2'd0,0,0,0, 1,2'd3,0,0,3'd2);  // beat alone does nothing
    add(0,0,0,0,0,2'd0,0,0,1, 0,2'd3,0,1,3'd4);  // done on last song -> GAP
    for (int i = 0; i < 7; i++) add(1,0,0,0,0,2'd0,0,0,0, 0,2'd3,0,1,3'd4);
    add(1,0,0,0,0,2'd0,0,0,0, 0,2'd0,0,0,3'd0);  // 8th beat: end of list -> IDLE
    add(0,0,0,0,1,2'd3,0,0,0, 0,2'd3,1,0,3'd1);  // emo start from idle
    add(0,0,0,0,0,2'd0,0,0,0, 1,2'd3,0,0,3'd2);
    add(0,0,0,0,0,2'd0,0,0,0, 1,2'd3,0,0,3'd2);
    add(0,0,0,0,0,2'd0,1,0,1, 0,2'd3,0,1,3'd4);  // done with loop_all
    for (int i = 0; i < 7; i++) add(1,0,0,0,0,2'd0,1,0,0, 0,2'd3,0,1,3'd4);
    add(1,0,0,0,0,2'd0,1,0,0, 0,2'd0,1,0,3'd1);  // wrap to song 0
    add(0,0,0,0,0,2'd0,1,0,0, 1,2'd0,0,0,3'd2);

    #12;
    chk("reset_state", 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].beat, vecs[i].pp, vecs[i].nx, vecs[i].pv, vecs[i].ev,
           vecs[i].es, vecs[i].la, vecs[i].lo, vecs[i].sd);
      chk($sformatf("tbl%0d", i), vecs[i].e_play, vecs[i].e_song,
          vecs[i].e_rst, vecs[i].e_gap, vecs[i].e_st);
    end

    // Reset while playing aborts at once without a restart pulse
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_mid_song", 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    // Song 1 auto-advance: only beats count down the gap
    step(0,0,0,0,1,2'd1,0,0,0); chk("a_load1", 1'b0, 2'd1, 1'b1, 1'b0, 3'd1);
    step(0,0,0,0,0,2'd0,0,0,0); chk("a_play1", 1'b1, 2'd1, 1'b0, 1'b0, 3'd2);
    step(0,0,0,0,0,2'd0,0,0,0);
    step(0,0,0,0,0,2'd0,0,0,1); chk("a_gap", 1'b0, 2'd1, 1'b0, 1'b1, 3'd4);
    for (int i = 0; i < 8; i++) begin
      step(0,0,0,0,0,2'd0,0,0,0);
      chk($sformatf("a_nobeat%0d", i), 1'b0, 2'd1, 1'b0, 1'b1, 3'd4);
      step(1,0,0,0,0,2'd0,0,0,0);
      if (i < 7) chk($sformatf("a_beat%0d", i), 1'b0, 2'd1, 1'b0, 1'b1, 3'd4);
      else       chk("a_expire", 1'b0, 2'd2, 1'b1, 1'b0, 3'd1);
    end
    step(0,0,0,0,0,2'd0,0,0,0); chk("a_play2", 1'b1, 2'd2, 1'b0, 1'b0, 3'd2);

    // loop_one wins over loop_all: same song reloads
    step(0,0,0,0,0,2'd0,1,1,0);
    step(0,0,0,0,0,2'd0,1,1,1); chk("b_gap", 1'b0, 2'd2, 1'b0, 1'b1, 3'd4);
    for (int i = 0; i < 8; i++) step(1,0,0,0,0,2'd0,1,1,0);
    chk("b_repeat", 1'b0, 2'd2, 1'b1, 1'b0, 3'd1);
    step(0,0,0,0,0,2'd0,0,0,0); chk("b_play2", 1'b1, 2'd2, 1'b0, 1'b0, 3'd2);

    // play_pause during gap stops, song held; restart uses that song
    step(0,0,0,0,0,2'd0,0,0,0);
    step(0,0,0,0,0,2'd0,0,0,1);
    step(1,0,0,0,0,2'd0,0,0,0); chk("c_gap", 1'b0, 2'd2, 1'b0, 1'b1, 3'd4);
    step(0,1,0,0,0,2'd0,0,0,0); chk("c_stop", 1'b0, 2'd2, 1'b0, 1'b0, 3'd0);
    step(0,1,0,0,0,2'd0,0,0,0); chk("c_restart", 1'b0, 2'd2, 1'b1, 1'b0, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
